// File: rtl/control_sequencer.sv
// Timing-and-control sequencer: steps fetch/execute through T0..T7 from the IR opcode
// and decodes the bus-driver strobes, load enables, memory strobes and ALU op.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        IRout,
  output logic        Yout,
  output logic        MARout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [2:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
  localparam logic [OPW-1:0] OP_LD   = OPW'(5);
  localparam logic [OPW-1:0] OP_ST   = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(7);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(8);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(9);
  localparam logic [OPW-1:0] OP_BR   = OPW'(10);
  localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_MUL = 3'd4;

  state_t         state;
  state_t         nxt;
  logic [OPW-1:0] op;
  logic           is_alu;
  logic           is_known;
  logic           unused_ir;

  assign op        = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];
  // add/sub/and/or share one step pattern; their opcode doubles as the ALU op.
  assign is_alu    = (op <= OP_OR);
  assign is_known  = (op <= OP_BR) || (op == OP_HALT);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_RST;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = mem_ready ? S_T2 : S_T1;
      S_T2:   nxt = is_known ? S_T3 : S_T0;
      S_T3: begin
        if (op == OP_HALT)                          nxt = S_HALT;
        else if ((op == OP_MFHI) || (op == OP_MFLO)) nxt = S_T0;
        else                                        nxt = S_T4;
      end
      S_T4:   nxt = S_T5;
      S_T5:   nxt = (is_alu || (op == OP_ADDI)) ? S_T0 : S_T6;
      S_T6: begin
        if (op == OP_LD)      nxt = mem_ready ? S_T7 : S_T6;
        else if (op == OP_ST) nxt = S_T7;
        else                  nxt = S_T0;
      end
      S_T7: begin
        if (op == OP_ST) nxt = mem_ready ? S_T0 : S_T7;
        else             nxt = S_T0;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  // Moore decode; con_ff only gates PCin during the branch T6 step.
  always_comb begin
    Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;  BAout = 1'b0;
    PCout = 1'b0;  MDRout = 1'b0;  Zlowout = 1'b0;  Zhighout = 1'b0;
    HIout = 1'b0;  LOout = 1'b0;  IRout = 1'b0;  Yout = 1'b0;  MARout = 1'b0;  Cout = 1'b0;
    PCin = 1'b0;  IRin = 1'b0;  MARin = 1'b0;  MDRin = 1'b0;  Yin = 1'b0;
    Zin = 1'b0;  HIin = 1'b0;  LOin = 1'b0;  CONin = 1'b0;  IncPC = 1'b0;
    Read = 1'b0;  Write = 1'b0;
    alu_op = ALU_ADD;
    run = 1'b1;
    case (state)
      S_T0: begin
        PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;  PCin = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;  IRin = 1'b1;
      end
      S_T3: begin
        if (is_alu || (op == OP_ADDI)) begin
          Grb = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
          Grb = 1'b1;  BAout = 1'b1;  Yin = 1'b1;
        end else if (op == OP_MUL) begin
          Gra = 1'b1;  Rout = 1'b1;  Yin = 1'b1;
        end else if (op == OP_MFHI) begin
          HIout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
        end else if (op == OP_MFLO) begin
          LOout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
        end else if (op == OP_BR) begin
          Gra = 1'b1;  Rout = 1'b1;  CONin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          Grc = 1'b1;  Rout = 1'b1;  Zin = 1'b1;  alu_op = op[2:0];
        end else if ((op == OP_ADDI) || (op == OP_LD) || (op == OP_ST)) begin
          Cout = 1'b1;  Zin = 1'b1;  alu_op = ALU_ADD;
        end else if (op == OP_MUL) begin
          Grb = 1'b1;  Rout = 1'b1;  Zin = 1'b1;  alu_op = ALU_MUL;
        end else if (op == OP_BR) begin
          PCout = 1'b1;  Yin = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || (op == OP_ADDI)) begin
          Zlowout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
          Zlowout = 1'b1;  MARin = 1'b1;
        end else if (op == OP_MUL) begin
          Zlowout = 1'b1;  LOin = 1'b1;
        end else if (op == OP_BR) begin
          Cout = 1'b1;  Zin = 1'b1;  alu_op = ALU_ADD;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          Read = 1'b1;  MDRin = 1'b1;
        end else if (op == OP_ST) begin
          Gra = 1'b1;  Rout = 1'b1;  MDRin = 1'b1;
        end else if (op == OP_MUL) begin
          Zhighout = 1'b1;  HIin = 1'b1;
        end else if (op == OP_BR) begin
          Zlowout = 1'b1;  PCin = con_ff;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          MDRout = 1'b1;  Gra = 1'b1;  Rin = 1'b1;
        end else if (op == OP_ST) begin
          Write = 1'b1;
        end
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected strobe word per
// cycle, a monitor on the falling edge pops and compares it against the DUT outputs.
module tb_control_sequencer;

  localparam logic [31:0] B_GRA    = 32'h8000_0000;
  localparam logic [31:0] B_GRB    = 32'h4000_0000;
  localparam logic [31:0] B_GRC    = 32'h2000_0000;
  localparam logic [31:0] B_RIN    = 32'h1000_0000;
  localparam logic [31:0] B_ROUT   = 32'h0800_0000;
  localparam logic [31:0] B_BAOUT  = 32'h0400_0000;
  localparam logic [31:0] B_PCOUT  = 32'h0200_0000;
  localparam logic [31:0] B_MDROUT = 32'h0100_0000;
  localparam logic [31:0] B_ZLO    = 32'h0080_0000;
  localparam logic [31:0] B_ZHI    = 32'h0040_0000;
  localparam logic [31:0] B_HIOUT  = 32'h0020_0000;
  localparam logic [31:0] B_LOOUT  = 32'h0010_0000;
  localparam logic [31:0] B_COUT   = 32'h0001_0000;
  localparam logic [31:0] B_PCIN   = 32'h0000_8000;
  localparam logic [31:0] B_IRIN   = 32'h0000_4000;
  localparam logic [31:0] B_MARIN  = 32'h0000_2000;
  localparam logic [31:0] B_MDRIN  = 32'h0000_1000;
  localparam logic [31:0] B_YIN    = 32'h0000_0800;
  localparam logic [31:0] B_ZIN    = 32'h0000_0400;
  localparam logic [31:0] B_HIIN   = 32'h0000_0200;
  localparam logic [31:0] B_LOIN   = 32'h0000_0100;
  localparam logic [31:0] B_CONIN  = 32'h0000_0080;
  localparam logic [31:0] B_INCPC  = 32'h0000_0040;
  localparam logic [31:0] B_READ   = 32'h0000_0020;
  localparam logic [31:0] B_WRITE  = 32'h0000_0010;
  localparam logic [31:0] A_SUB    = 32'h0000_0002;
  localparam logic [31:0] A_MUL    = 32'h0000_0008;
  localparam logic [31:0] B_RUN    = 32'h0000_0001;
  localparam logic [31:0] BUS_MASK = 32'h0FFF_0000;

  localparam logic [31:0] E_RST = B_RUN;
  localparam logic [31:0] E_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;
  localparam logic [31:0] E_T1  = B_ZLO | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [31:0] E_T2  = B_MDROUT | B_IRIN | B_RUN;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_ff = 1'b0;
  logic        mem_ready = 1'b1;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, MDRout, Zlowout, Zhighout;
  logic HIout, LOout, IRout, Yout, MARout, Cout, PCin, IRin, MARin, MDRin;
  logic Yin, Zin, HIin, LOin, CONin, IncPC, Read, Write, run;
  logic [2:0]  alu_op;
  logic [31:0] act;

  typedef struct {
    logic [31:0] exp;
    int          test;
    int          step;
  } item_t;

  item_t exp_q[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cur_test = 0;
  int    cur_step = 0;

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear_n(clear_n), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIout(HIout), .LOout(LOout), .IRout(IRout), .Yout(Yout), .MARout(MARout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
  );

  assign act = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, MDRout, Zlowout, Zhighout,
                HIout, LOout, IRout, Yout, MARout, Cout, PCin, IRin, MARin, MDRin,
                Yin, Zin, HIin, LOin, CONin, IncPC, Read, Write, alu_op, run};

  always #5 clock = ~clock;

  always @(negedge clock) begin
    item_t it;
    if ($countones(act & BUS_MASK) > 1) begin
      mismatched++;
      $display("FAIL bus_driver t%0d: drivers=%h allowed at most one", cur_test, act & BUS_MASK);
    end
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      compared++;
      if (act !== it.exp) begin
        mismatched++;
        $display("FAIL t%0d step%0d: got=%h want=%h", it.test, it.step, act, it.exp);
      end
    end
  end

  task automatic push(input logic [31:0] e);
    item_t it;
    it.exp = e;
    it.test = cur_test;
    it.step = cur_step;
    exp_q.push_back(it);
    cur_step++;
  endtask

  task automatic step(input logic [31:0] e, input logic mr, input logic cf);
    mem_ready = mr;
    con_ff = cf;
    push(e);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] v, input int t1_wait);
    cur_test++;
    cur_step = 0;
    ir = v;
    step(E_T0, 1'b1, 1'b0);
    for (int i = 0; i < t1_wait; i++) step(E_T1, 1'b0, 1'b0);
    step(E_T1, 1'b1, 1'b0);
    step(E_T2, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    push(E_RST);
    @(posedge clock);
    #1;
    clear_n = 1'b1;
    @(posedge clock);
    #1;

    // add, with memory slow in the fetch read
    fetch(32'h0000_0000, 2);
    step(B_GRB | B_ROUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_GRC | B_ROUT | B_ZIN | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);

    // sub: alu_op follows the opcode
    fetch(32'h0800_0000, 0);
    step(B_GRB | B_ROUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_GRC | B_ROUT | B_ZIN | A_SUB | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);

    // addi
    fetch(32'h2000_0000, 0);
    step(B_GRB | B_ROUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_COUT | B_ZIN | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);

    // ld with three wait cycles in T6
    fetch(32'h2800_0000, 0);
    step(B_GRB | B_BAOUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_COUT | B_ZIN | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_MARIN | B_RUN, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(B_READ | B_MDRIN | B_RUN, 1'b0, 1'b0);
    step(B_READ | B_MDRIN | B_RUN, 1'b1, 1'b0);
    step(B_MDROUT | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);

    // st with one wait cycle in T7
    fetch(32'h3000_0000, 0);
    step(B_GRB | B_BAOUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_COUT | B_ZIN | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_MARIN | B_RUN, 1'b0, 1'b0);
    step(B_GRA | B_ROUT | B_MDRIN | B_RUN, 1'b0, 1'b0);
    step(B_WRITE | B_RUN, 1'b0, 1'b0);
    step(B_WRITE | B_RUN, 1'b1, 1'b0);

    // mul
    fetch(32'h3800_0000, 0);
    step(B_GRA | B_ROUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_GRB | B_ROUT | B_ZIN | A_MUL | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_LOIN | B_RUN, 1'b1, 1'b0);
    step(B_ZHI | B_HIIN | B_RUN, 1'b1, 1'b0);

    // mfhi, mflo
    fetch(32'h4000_0000, 0);
    step(B_HIOUT | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);
    fetch(32'h4800_0000, 0);
    step(B_LOOUT | B_GRA | B_RIN | B_RUN, 1'b1, 1'b0);

    // br not taken, then taken
    for (int c = 0; c < 2; c++) begin
      fetch(32'h5000_0000, 0);
      step(B_GRA | B_ROUT | B_CONIN | B_RUN, 1'b1, 1'b0);
      step(B_PCOUT | B_YIN | B_RUN, 1'b1, 1'b0);
      step(B_COUT | B_ZIN | B_RUN, 1'b1, 1'b0);
      step(B_ZLO | (c == 1 ? B_PCIN : 32'h0) | B_RUN, 1'b1, c == 1);
    end

    // unknown opcode behaves as nop
    fetch(32'h6000_0000, 0);

    // ld interrupted by reset while waiting in T6
    fetch(32'h2800_0000, 0);
    step(B_GRB | B_BAOUT | B_YIN | B_RUN, 1'b1, 1'b0);
    step(B_COUT | B_ZIN | B_RUN, 1'b1, 1'b0);
    step(B_ZLO | B_MARIN | B_RUN, 1'b0, 1'b0);
    clear_n = 1'b0;
    step(E_RST, 1'b0, 1'b0);
    clear_n = 1'b1;
    step(E_RST, 1'b1, 1'b0);

    // halt: run drops after T3 and stays low
    fetch(32'hF800_0000, 0);
    step(B_RUN, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(32'h0, 1'b1, 1'b0);

    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
